// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter. Bytes pushed into a small
// first-word-fall-through FIFO are framed (start, 5-8 data bits LSB first,
// optional parity, 1 or 2 stop bits) and shifted onto a registered serial
// line, one bit per strobe from an external baud generator.

module sync_fifo_fwft_with_clear #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             wr_ok;
    logic             rd_ok;

    // Clear has priority over both ports so a flush never leaves stale data.
    assign wr_ok = wr_en && !full && !clear;
    assign rd_ok = rd_en && !empty && !clear;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    // Head is read combinationally so it is valid the cycle after it is written.
    assign rd_data = mem[rd_ptr_reg];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    // Storage array write port (no reset on data).
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous write and read leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (rd_ok) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({wr_ok, rd_ok})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end
endmodule

module uart_tx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_parity,
    input  logic [1:0] i_data_bits,
    input  logic       i_stop_bits,
    input  logic       i_use_parity,
    input  logic [2:0] i_threshold_value,
    output logic       o_threshold,
    input  logic       i_fifo_clear,
    input  logic       i_fifo_wr_en,
    input  logic [7:0] i_fifo_wr_data,
    output logic       o_fifo_full,
    output logic       o_fifo_empty,
    input  logic       i_tx_strb,
    output logic       o_tx_strb_en,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_overflow_error
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, DATA, PARITY, STOP0, STOP1, DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt_reg;
    logic          parity_reg;
    logic [1:0]    data_bits_reg;
    logic          use_parity_reg;
    logic          stop2_reg;
    logic          tx_reg, tx_next;
    logic          overflow_reg;
    logic          threshold_reg;
    logic          fifo_rd;
    logic [7:0]    fifo_rd_data;
    logic [LW-1:0] fifo_level;
    logic          wr_accept;
    logic          have_data;
    logic          last_bit;
    logic [4:0]    thr_level;

    sync_fifo_fwft_with_clear #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (i_fifo_clear),
        .wr_en   (i_fifo_wr_en),
        .wr_data (i_fifo_wr_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (o_fifo_full),
        .empty   (o_fifo_empty),
        .level   (fifo_level)
    );

    // A byte accepted this cycle is already the FIFO head next cycle, so the
    // FSM may head for LOAD on the write itself; a clear cancels both.
    assign wr_accept = i_fifo_wr_en && !o_fifo_full && !i_fifo_clear;
    assign have_data = !i_fifo_clear && (!o_fifo_empty || wr_accept);
    assign last_bit  = (bit_cnt_reg == (3'd4 + {1'b0, data_bits_reg}));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; strobes only advance the bit-timed states.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (have_data) state_next = LOAD;
            LOAD:    state_next = START;
            START:   if (i_tx_strb) state_next = DATA;
            DATA:    if (i_tx_strb && last_bit) state_next = use_parity_reg ? PARITY : STOP0;
            PARITY:  if (i_tx_strb) state_next = STOP0;
            STOP0:   if (i_tx_strb) state_next = stop2_reg ? STOP1 : DONE;
            STOP1:   if (i_tx_strb) state_next = DONE;
            DONE:    state_next = have_data ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        tx_next      = 1'b1;
        o_tx_strb_en = 1'b0;
        fifo_rd      = 1'b0;
        o_busy       = (state_reg != IDLE);
        case (state_reg)
            LOAD:    fifo_rd = 1'b1;
            START:   begin tx_next = 1'b0;         o_tx_strb_en = 1'b1; end
            DATA:    begin tx_next = shift_reg[0]; o_tx_strb_en = 1'b1; end
            PARITY:  begin tx_next = parity_reg;   o_tx_strb_en = 1'b1; end
            STOP0:   o_tx_strb_en = 1'b1;
            STOP1:   o_tx_strb_en = 1'b1;
            default: ;
        endcase
    end

    // Frame datapath: capture byte and framing config at LOAD, shift on strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            parity_reg     <= 1'b0;
            data_bits_reg  <= '0;
            use_parity_reg <= 1'b0;
            stop2_reg      <= 1'b0;
        end else if (state_reg == LOAD) begin
            shift_reg      <= fifo_rd_data;
            bit_cnt_reg    <= '0;
            parity_reg     <= i_parity;
            data_bits_reg  <= i_data_bits;
            use_parity_reg <= i_use_parity;
            stop2_reg      <= i_stop_bits;
        end else if (state_reg == DATA && i_tx_strb) begin
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            parity_reg  <= parity_reg ^ shift_reg[0];
        end
    end

    // Empty-threshold level select.
    always_comb begin
        thr_level = 5'd0;
        case (i_threshold_value)
            3'd0: thr_level = 5'd0;
            3'd1: thr_level = 5'd1;
            3'd2: thr_level = 5'd2;
            3'd3: thr_level = 5'd4;
            3'd4: thr_level = 5'd8;
            3'd5: thr_level = 5'd10;
            3'd6: thr_level = 5'd12;
            3'd7: thr_level = 5'd14;
            default: thr_level = 5'd0;
        endcase
    end

    // Registered line, overflow pulse and threshold flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_reg        <= 1'b1;
            overflow_reg  <= 1'b0;
            threshold_reg <= 1'b0;
        end else begin
            tx_reg        <= tx_next;
            overflow_reg  <= i_fifo_wr_en && o_fifo_full;
            threshold_reg <= (5'(fifo_level) <= thr_level);
        end
    end

    assign o_uart_tx        = tx_reg;
    assign o_overflow_error = overflow_reg;
    assign o_threshold      = threshold_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: models the baud generator, captures the line value
// at every bit-ending strobe, and compares frames against expected bit lists.
`timescale 1ns/1ps
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_parity, i_stop_bits, i_use_parity;
    logic [1:0] i_data_bits;
    logic [2:0] i_threshold_value;
    logic       i_fifo_clear, i_fifo_wr_en;
    logic [7:0] i_fifo_wr_data;
    logic       i_tx_strb;
    logic       o_threshold, o_fifo_full, o_fifo_empty;
    logic       o_tx_strb_en, o_uart_tx, o_busy, o_overflow_error;

    logic gen_strb = 1'b0;
    logic man_strb = 1'b0;
    int   period = 16;
    int   strb_cnt = 0;
    int   low_cycles = 0;
    logic line_q[$];
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [1:0] db;
        logic       up;
        logic       sb;
        logic       par;
        logic [7:0] data;
        int         period;
        string      line;
    } vec_t;

    int thr_map[8] = '{0, 1, 2, 4, 8, 10, 12, 14};

    assign i_tx_strb = gen_strb | man_strb;

    always #5 clk = ~clk;

    uart_tx #(.FIFO_DEPTH(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_parity          (i_parity),
        .i_data_bits       (i_data_bits),
        .i_stop_bits       (i_stop_bits),
        .i_use_parity      (i_use_parity),
        .i_threshold_value (i_threshold_value),
        .o_threshold       (o_threshold),
        .i_fifo_clear      (i_fifo_clear),
        .i_fifo_wr_en      (i_fifo_wr_en),
        .i_fifo_wr_data    (i_fifo_wr_data),
        .o_fifo_full       (o_fifo_full),
        .o_fifo_empty      (o_fifo_empty),
        .i_tx_strb         (i_tx_strb),
        .o_tx_strb_en      (o_tx_strb_en),
        .o_uart_tx         (o_uart_tx),
        .o_busy            (o_busy),
        .o_overflow_error  (o_overflow_error)
    );

    // Baud generator (restarts while enable is low) and line monitor.
    always @(negedge clk) begin
        if (o_tx_strb_en !== 1'b1) begin
            strb_cnt = 0;
            gen_strb = 1'b0;
        end else begin
            strb_cnt = strb_cnt + 1;
            gen_strb = (strb_cnt >= period);
            if (gen_strb) strb_cnt = 0;
        end
        if (gen_strb && o_tx_strb_en === 1'b1) line_q.push_back(o_uart_tx);
        if (o_uart_tx === 1'b0) low_cycles++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic up, input logic sb, input logic par);
        i_data_bits  = db;
        i_use_parity = up;
        i_stop_bits  = sb;
        i_parity     = par;
    endtask

    task automatic push(input logic [7:0] d, output logic ovf);
        i_fifo_wr_en   = 1'b1;
        i_fifo_wr_data = d;
        tick();
        i_fifo_wr_en   = 1'b0;
        ovf = o_overflow_error;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, o_busy, n);
        end
    endtask

    // Expected line bits for one frame, bit 0 first on the wire.
    function automatic int model_frame(input logic [1:0] db, input logic up, input logic sb,
                                       input logic par, input logic [7:0] d,
                                       output logic [11:0] bits);
        int w, n, ones;
        w = 5 + int'(db);
        bits = '1;
        bits[0] = 1'b0;
        n = 1;
        ones = 0;
        for (int i = 0; i < w; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (up) begin
            bits[n] = par ^ ones[0];
            n++;
        end
        n += sb ? 2 : 1;
        return n;
    endfunction

    function automatic logic [11:0] str_bits(input string s);
        logic [11:0] b;
        b = '1;
        for (int i = 0; i < s.len(); i++) b[i] = (s[i] == "1");
        return b;
    endfunction

    function automatic int str_zeros(input string s);
        int z;
        z = 0;
        for (int i = 0; i < s.len(); i++) if (s[i] == "0") z++;
        return z;
    endfunction

    task automatic check_frame(input string name, input logic [11:0] exp_bits, input int n);
        logic [11:0] got;
        got = '1;
        if (line_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s: captured %0d line bits, required %0d", name, line_q.size(), n);
            line_q.delete();
        end else begin
            for (int i = 0; i < n; i++) got[i] = line_q.pop_front();
            $display("frame %s: line %b expected %b (first bit rightmost)", name, got, exp_bits);
            check(name, 32'(got), 32'(exp_bits));
        end
    endtask

    function automatic vec_t mk(input logic [1:0] db, input logic up, input logic sb,
                                input logic par, input logic [7:0] d, input int p, input string s);
        vec_t v;
        v.db = db; v.up = up; v.sb = sb; v.par = par; v.data = d; v.period = p; v.line = s;
        return v;
    endfunction

    initial begin
        vec_t        vecs[6];
        logic        ovf;
        logic [11:0] fb;
        int          fn, n, gaps, nbytes;
        logic [11:0] exp_f[$];
        int          exp_n[$];
        logic [7:0]  b;

        vecs[0] = mk(2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 16, "0101001011");
        vecs[1] = mk(2'd2, 1'b1, 1'b1, 1'b0, 8'h7F, 8,  "01111111111");
        vecs[2] = mk(2'd0, 1'b1, 1'b0, 1'b1, 8'h03, 8,  "01100011");
        vecs[3] = mk(2'd3, 1'b1, 1'b1, 1'b1, 8'h00, 4,  "000000000111");
        vecs[4] = mk(2'd1, 1'b0, 1'b0, 1'b0, 8'h2D, 3,  "01011011");
        vecs[5] = mk(2'd3, 1'b1, 1'b0, 1'b0, 8'h81, 5,  "01000000101");

        rst_n = 1'b0;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        i_threshold_value = 3'd0;
        i_fifo_clear = 1'b0;
        i_fifo_wr_en = 1'b0;
        i_fifo_wr_data = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_tx", o_uart_tx, 1'b1);
        check("rst_strb_en", o_tx_strb_en, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ovf", o_overflow_error, 1'b0);
        check("rst_threshold", o_threshold, 1'b0);
        check("rst_empty", o_fifo_empty, 1'b1);
        check("rst_full", o_fifo_full, 1'b0);
        rst_n = 1'b1;
        tick();
        check("threshold_after_rst", o_threshold, 1'b1);

        // Table of single frames; config is scrambled once the frame is latched.
        for (int v = 0; v < 6; v++) begin
            set_cfg(vecs[v].db, vecs[v].up, vecs[v].sb, vecs[v].par);
            period = vecs[v].period;
            line_q.delete();
            low_cycles = 0;
            push(vecs[v].data, ovf);
            check($sformatf("vec%0d_empty_after_write", v), o_fifo_empty, 1'b0);
            tick();
            check($sformatf("vec%0d_strb_en_start", v), o_tx_strb_en, 1'b1);
            set_cfg(~vecs[v].db, ~vecs[v].up, ~vecs[v].sb, ~vecs[v].par);
            wait_idle($sformatf("vec%0d_idle", v), 20 * period + 20);
            check_frame($sformatf("vec%0d", v), str_bits(vecs[v].line), vecs[v].line.len());
            check($sformatf("vec%0d_low_cycles", v), low_cycles, period * str_zeros(vecs[v].line));
            check($sformatf("vec%0d_idle_line", v), o_uart_tx, 1'b1);
        end

        // Randomised bursts against the frame model
        for (int r = 0; r < 12; r++) begin
            set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            period = $urandom_range(2, 5);
            nbytes = $urandom_range(1, 4);
            line_q.delete();
            exp_f.delete();
            exp_n.delete();
            for (int k = 0; k < nbytes; k++) begin
                b = 8'($urandom);
                fn = model_frame(i_data_bits, i_use_parity, i_stop_bits, i_parity, b, fb);
                exp_f.push_back(fb);
                exp_n.push_back(fn);
                push(b, ovf);
            end
            wait_idle($sformatf("rnd%0d_idle", r), nbytes * (13 * period + 4) + 50);
            for (int k = 0; k < nbytes; k++)
                check_frame($sformatf("rnd%0d_f%0d", r, k), exp_f[k], exp_n[k]);
        end

        // Overflow and back-to-back frames: first byte leaves at once, 16 fill the FIFO
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        period = 4;
        line_q.delete();
        exp_f.delete();
        for (int k = 0; k < 18; k++) begin
            b = 8'(k * 29 + 3);
            push(b, ovf);
            check($sformatf("ovf_w%0d", k), ovf, (k == 17));
            if (k < 17) begin
                fn = model_frame(2'd3, 1'b0, 1'b0, 1'b0, b, fb);
                exp_f.push_back(fb);
            end
            if (k == 16) check("full_after_fill", o_fifo_full, 1'b1);
        end
        tick();
        check("ovf_single_cycle", o_overflow_error, 1'b0);
        n = 0;
        gaps = 0;
        while (line_q.size() < 170 && n < 3000) begin
            tick();
            n++;
            if (o_busy !== 1'b1) gaps++;
        end
        check("b2b_idle_gaps", gaps, 0);
        wait_idle("b2b_idle", 100);
        for (int k = 0; k < 17; k++) check_frame($sformatf("b2b_f%0d", k), exp_f[k], 10);
        check("b2b_no_extra_frame", line_q.size(), 0);

        // Threshold flag
        i_threshold_value = 3'b011;
        tick();
        tick();
        check("thr_empty", o_threshold, 1'b1);
        line_q.delete();
        for (int k = 0; k < 7; k++) push(8'(k + 8'h40), ovf);
        tick();
        check("thr_level6", o_threshold, 1'b0);
        for (int c = 0; c < 8; c++) begin
            i_threshold_value = 3'(c);
            tick();
            tick();
            check($sformatf("thr_map%0d", c), o_threshold, (6 <= thr_map[c]));
        end
        i_threshold_value = 3'b011;
        tick();
        tick();
        check("thr_restore", o_threshold, 1'b0);
        n = 0;
        while (o_threshold !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("thr_rise_after_two_frames", line_q.size(), 20);
        wait_idle("thr_idle", 400);
        line_q.delete();
        check("thr_drained", o_threshold, 1'b1);

        // Clear flushes queued bytes; frame in flight completes; clear beats write
        line_q.delete();
        push(8'h3C, ovf);
        push(8'hC3, ovf);
        push(8'h99, ovf);
        i_fifo_clear = 1'b1;
        push(8'h11, ovf);
        i_fifo_clear = 1'b0;
        check("clear_empty", o_fifo_empty, 1'b1);
        wait_idle("clear_idle", 200);
        fn = model_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, fb);
        check_frame("clear_inflight", fb, fn);
        check("clear_no_more_frames", line_q.size(), 0);

        // Strobes while idle do nothing
        man_strb = 1'b1;
        tick();
        tick();
        tick();
        man_strb = 1'b0;
        check("idle_strb_busy", o_busy, 1'b0);
        check("idle_strb_line", o_uart_tx, 1'b1);

        // Reset in the middle of a data bit
        line_q.delete();
        push(8'h0F, ovf);
        push(8'hF0, ovf);
        push(8'h55, ovf);
        n = 0;
        while (line_q.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        check("midrst_reached_data", (line_q.size() >= 3), 1'b1);
        rst_n = 1'b0;
        tick();
        check("midrst_tx", o_uart_tx, 1'b1);
        check("midrst_strb_en", o_tx_strb_en, 1'b0);
        check("midrst_empty", o_fifo_empty, 1'b1);
        check("midrst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        line_q.delete();
        for (int k = 0; k < 60; k++) tick();
        check("midrst_no_resume", line_q.size(), 0);
        check("midrst_stays_idle", o_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
